// File: rtl/game_move_engine.sv
// rtl/game_move_engine.sv - Sokoban move engine with undo history and move/push counters
//
// Purpose: holds the live board {way,box,man}, executes one command per request
// (explicit direction, move toward cursor, undo), keeps a circular undo history
// and saturating move/push counters, and flags a win when all targets hold boxes.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   load_i              load state_in_i/target_i, clear history and counters, abort command
//   state_in_i          {way,box,man}, man = {y,x}
//   target_i            goal-cell map
//   req_i, cmd_i        command request (taken only when idle) and opcode
//   dir_i, cursor_i     explicit direction / cursor {y,x}
//   state_out_o         current {way,box,man}
//   busy_o, done_o      command in flight / one-cycle completion pulse
//   result_o            with done_o: board changed
//   direction_o         with done_o: direction used (undo: original move direction)
//   move_cnt_o          successful moves
//   push_cnt_o          successful pushes
//   undo_avail_o        history non-empty
//   win_o               every target cell holds a box
module game_move_engine #(
    parameter int  XW    = 3,
    parameter int  YW    = 3,
    parameter int  DEPTH = 16,
    parameter int  CNT_W = 16,
    localparam int AW    = XW + YW,
    localparam int CELLS = 1 << AW,
    localparam int SW    = 2 * CELLS + AW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [SW-1:0]    state_in_i,
    input  logic [CELLS-1:0] target_i,
    input  logic             req_i,
    input  logic [1:0]       cmd_i,
    input  logic [1:0]       dir_i,
    input  logic [AW-1:0]    cursor_i,
    output logic [SW-1:0]    state_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             result_o,
    output logic [1:0]       direction_o,
    output logic [CNT_W-1:0] move_cnt_o,
    output logic [CNT_W-1:0] push_cnt_o,
    output logic             undo_avail_o,
    output logic             win_o
);

    localparam int HW = $clog2(DEPTH);
    localparam int CW = HW + 1;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] CMD_DIR    = 2'd0;
    localparam logic [1:0] CMD_CURSOR = 2'd1;
    localparam logic [1:0] CMD_UNDO   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_COMMIT} state_t;

    state_t state_q, state_d;

    logic [CELLS-1:0] way_q, box_q, target_q;
    logic [AW-1:0]    man_q;
    logic [CNT_W-1:0] move_cnt_q, push_cnt_q;
    logic [HW-1:0]    wr_ptr_q;
    logic [CW-1:0]    hist_cnt_q;
    logic [2:0]       hist_q [DEPTH];  // {dir, pushed}

    logic [1:0]       cmd_q, dir_q;
    logic [AW-1:0]    cursor_q;

    logic             ev_res_q, ev_push_q, ev_undo_q;
    logic             ev_res_d, ev_push_d, ev_undo_d;
    logic [AW-1:0]    ev_next_q, ev_skip_q, ev_next_d, ev_skip_d;
    logic [1:0]       ev_dir_q, ev_dir_d;

    logic             done_q, result_q, win_q, win_upd_q;
    logic [1:0]       direction_q;

    logic             accept, commit_en;

    // One step from pos in direction d; MSB flags leaving the grid.
    function automatic logic [AW:0] step(input logic [AW-1:0] pos, input logic [1:0] d);
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          oob;
        x   = pos[XW-1:0];
        y   = pos[AW-1:XW];
        oob = 1'b0;
        case (d)
            DIR_UP:    begin oob = (y == '0); y = y - YW'(1); end
            DIR_DOWN:  begin oob = (y == '1); y = y + YW'(1); end
            DIR_LEFT:  begin oob = (x == '0); x = x - XW'(1); end
            default:   begin oob = (x == '1); x = x + XW'(1); end
        endcase
        return {oob, y, x};
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (req_i) state_d = S_EVAL;
                S_EVAL:   state_d = S_COMMIT;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o    = (state_q != S_IDLE);
        accept    = (state_q == S_IDLE) && req_i && !load_i;
        commit_en = (state_q == S_COMMIT) && !load_i;
    end

    // ---------------- Evaluation of the latched command ----------------
    logic [XW-1:0] cx, mx;
    logic [YW-1:0] cy, my;
    logic [AW-1:0] adx, ady;
    logic [1:0]    cur_dir, mv_dir;
    logic [AW:0]   st_n, st_s, un_n, un_s;
    logic [HW-1:0] rd_ptr;
    logic [2:0]    hist_top;

    always_comb begin
        cx = cursor_q[XW-1:0];
        cy = cursor_q[AW-1:XW];
        mx = man_q[XW-1:0];
        my = man_q[AW-1:XW];
        adx = (cx > mx) ? AW'(cx - mx) : AW'(mx - cx);
        ady = (cy > my) ? AW'(cy - my) : AW'(my - cy);
        // Ties resolve vertically.
        if (adx > ady) cur_dir = (cx > mx) ? DIR_RIGHT : DIR_LEFT;
        else           cur_dir = (cy > my) ? DIR_DOWN  : DIR_UP;

        mv_dir   = (cmd_q == CMD_CURSOR) ? cur_dir : dir_q;
        st_n     = step(man_q, mv_dir);
        st_s     = step(st_n[AW-1:0], mv_dir);
        rd_ptr   = wr_ptr_q - HW'(1);
        hist_top = hist_q[rd_ptr];
        // Undo walks the man back (opposite dir = d^1); a pushed box sits one step ahead.
        un_n     = step(man_q, hist_top[2:1] ^ 2'b01);
        un_s     = step(man_q, hist_top[2:1]);

        ev_res_d  = 1'b0;
        ev_push_d = 1'b0;
        ev_undo_d = 1'b0;
        ev_dir_d  = dir_q;
        ev_next_d = st_n[AW-1:0];
        ev_skip_d = st_s[AW-1:0];

        case (cmd_q)
            CMD_DIR, CMD_CURSOR: begin
                ev_dir_d = mv_dir;
                if (!((cmd_q == CMD_CURSOR) && (cursor_q == man_q)) && !st_n[AW]) begin
                    if (way_q[st_n[AW-1:0]]) begin
                        ev_res_d = 1'b1;
                    end else if (box_q[st_n[AW-1:0]] && !st_s[AW] && way_q[st_s[AW-1:0]]) begin
                        ev_res_d  = 1'b1;
                        ev_push_d = 1'b1;
                    end
                end
            end
            CMD_UNDO: begin
                if (hist_cnt_q != '0) begin
                    ev_res_d  = 1'b1;
                    ev_undo_d = 1'b1;
                    ev_dir_d  = hist_top[2:1];
                    ev_push_d = hist_top[0];
                    ev_next_d = un_n[AW-1:0];
                    ev_skip_d = un_s[AW-1:0];
                end
            end
            default: ;
        endcase
    end

    // ---------------- Board, counters, history pointers ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            way_q       <= '0;
            box_q       <= '0;
            man_q       <= '0;
            target_q    <= '0;
            move_cnt_q  <= '0;
            push_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            hist_cnt_q  <= '0;
            cmd_q       <= '0;
            dir_q       <= '0;
            cursor_q    <= '0;
            ev_res_q    <= 1'b0;
            ev_push_q   <= 1'b0;
            ev_undo_q   <= 1'b0;
            ev_next_q   <= '0;
            ev_skip_q   <= '0;
            ev_dir_q    <= '0;
            done_q      <= 1'b0;
            result_q    <= 1'b0;
            direction_q <= '0;
            win_q       <= 1'b0;
            win_upd_q   <= 1'b0;
        end else if (load_i) begin
            way_q      <= state_in_i[SW-1 -: CELLS];
            box_q      <= state_in_i[AW +: CELLS];
            man_q      <= state_in_i[AW-1:0];
            target_q   <= target_i;
            move_cnt_q <= '0;
            push_cnt_q <= '0;
            wr_ptr_q   <= '0;
            hist_cnt_q <= '0;
            done_q     <= 1'b0;
            win_upd_q  <= 1'b1;
        end else begin
            done_q    <= 1'b0;
            win_upd_q <= 1'b0;
            // Win is re-derived one cycle after the board settles.
            if (win_upd_q) win_q <= &(~target_q | box_q);

            if (accept) begin
                cmd_q    <= cmd_i;
                dir_q    <= dir_i;
                cursor_q <= cursor_i;
            end

            if (state_q == S_EVAL) begin
                ev_res_q  <= ev_res_d;
                ev_push_q <= ev_push_d;
                ev_undo_q <= ev_undo_d;
                ev_next_q <= ev_next_d;
                ev_skip_q <= ev_skip_d;
                ev_dir_q  <= ev_dir_d;
            end

            if (commit_en) begin
                done_q      <= 1'b1;
                result_q    <= ev_res_q;
                direction_q <= ev_dir_q;
                win_upd_q   <= 1'b1;
                if (ev_res_q) begin
                    man_q <= ev_next_q;
                    if (ev_undo_q) begin
                        if (ev_push_q) begin
                            way_q[ev_skip_q] <= 1'b1;
                            way_q[man_q]     <= 1'b0;
                            box_q[ev_skip_q] <= 1'b0;
                            box_q[man_q]     <= 1'b1;
                            if (push_cnt_q != '0) push_cnt_q <= push_cnt_q - CNT_W'(1);
                        end
                        if (move_cnt_q != '0) move_cnt_q <= move_cnt_q - CNT_W'(1);
                        wr_ptr_q   <= wr_ptr_q - HW'(1);
                        hist_cnt_q <= hist_cnt_q - CW'(1);
                    end else begin
                        if (ev_push_q) begin
                            way_q[ev_next_q] <= 1'b1;
                            way_q[ev_skip_q] <= 1'b0;
                            box_q[ev_next_q] <= 1'b0;
                            box_q[ev_skip_q] <= 1'b1;
                            if (push_cnt_q != '1) push_cnt_q <= push_cnt_q + CNT_W'(1);
                        end
                        if (move_cnt_q != '1) move_cnt_q <= move_cnt_q + CNT_W'(1);
                        // A full history overwrites its oldest entry.
                        wr_ptr_q <= wr_ptr_q + HW'(1);
                        if (hist_cnt_q != CW'(DEPTH)) hist_cnt_q <= hist_cnt_q + CW'(1);
                    end
                end
            end
        end
    end

    // History storage needs no reset: entries are only read below hist_cnt_q.
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit_en && ev_res_q && !ev_undo_q)
            hist_q[wr_ptr_q] <= {ev_dir_q, ev_push_q};
    end

    assign state_out_o  = {way_q, box_q, man_q};
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign direction_o  = direction_q;
    assign move_cnt_o   = move_cnt_q;
    assign push_cnt_o   = push_cnt_q;
    assign undo_avail_o = (hist_cnt_q != '0);
    assign win_o        = win_q;

endmodule
